// File: rtl/rtds_frame_relay.sv
// Store-and-forward relay: buffers one RTDS frame from Aurora RX, waits cfg_delay cycles, replays it to Aurora TX.
// Latency: first TX beat 1+cfg_delay cycles after the RX tlast handshake; one beat per cycle while m_axis_tready is high.
// Backpressure: RX cannot be stalled; beats arriving in WAIT/SEND are discarded (tready low). TX honours m_axis_tready.
module rtds_frame_relay #(
    parameter int DATA_WIDTH  = 32,
    parameter int MAX_WORDS   = 64,
    parameter int DELAY_WIDTH = 16,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   user_clk,
    input  logic                   sys_reset,
    input  logic [DELAY_WIDTH-1:0] cfg_delay,
    input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic                   s_axis_tvalid,
    input  logic                   s_axis_tlast,
    output logic                   s_axis_tready,
    output logic [DATA_WIDTH-1:0]  m_axis_tdata,
    output logic                   m_axis_tvalid,
    output logic                   m_axis_tlast,
    input  logic                   m_axis_tready,
    output logic                   rtds_tx_pulse,
    output logic [CNT_WIDTH-1:0]   frame_count,
    output logic [CNT_WIDTH-1:0]   drop_count,
    output logic                   overflow_err
);

    localparam int AW = $clog2(MAX_WORDS);
    localparam int LW = AW + 1;
    localparam logic [AW-1:0] LAST_IDX = AW'(MAX_WORDS - 1);

    typedef enum logic [1:0] {
        ST_RECV = 2'd0,
        ST_DROP = 2'd1,
        ST_WAIT = 2'd2,
        ST_SEND = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [DATA_WIDTH-1:0]  mem [MAX_WORDS];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [LW-1:0]          len;
    logic [DELAY_WIDTH-1:0] dcnt;
    logic                   in_frame;
    logic                   in_frame_nxt;
    logic                   ready_en;
    logic                   pulse_done;
    logic                   rx_acc;
    logic                   last_word;
    logic                   tx_hs;
    logic                   tx_end;
    logic                   drop_hit;

    // A beat is only taken when the relay says ready; everything else from Aurora is lost.
    assign rx_acc       = s_axis_tvalid & s_axis_tready;
    // Frame-in-progress view of the RX stream as it will be after this cycle, whatever our state.
    assign in_frame_nxt = s_axis_tvalid ? ~s_axis_tlast : in_frame;
    assign last_word    = ({1'b0, rd_ptr} == (len - LW'(1)));
    assign tx_hs        = (state == ST_SEND) & m_axis_tready;
    assign tx_end       = tx_hs & last_word;
    // Drops: a frame finishing inside DROP, or any tlast beat thrown away while busy.
    assign drop_hit     = ((state == ST_DROP) & rx_acc & s_axis_tlast)
                        | (((state == ST_WAIT) | (state == ST_SEND)) & s_axis_tvalid & s_axis_tlast);

    // State register.
    always_ff @(posedge user_clk or posedge sys_reset) begin
        if (sys_reset) state <= ST_RECV;
        else           state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RECV: begin
                if (rx_acc) begin
                    if (s_axis_tlast)
                        state_nxt = (cfg_delay == '0) ? ST_SEND : ST_WAIT;
                    else if (wr_ptr == LAST_IDX)
                        state_nxt = ST_DROP;
                end
            end
            ST_DROP: begin
                if (rx_acc && s_axis_tlast) state_nxt = ST_RECV;
            end
            ST_WAIT: begin
                if (dcnt == DELAY_WIDTH'(1)) state_nxt = ST_SEND;
            end
            ST_SEND: begin
                // A tlast beat landing in the exit cycle ends the intruding frame, so RECV is safe.
                if (tx_end) state_nxt = in_frame_nxt ? ST_DROP : ST_RECV;
            end
            default: state_nxt = ST_RECV;
        endcase
    end

    // Output decode; TX fields are forced to zero outside SEND so reset shows clean outputs.
    always_comb begin
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tlast  = 1'b0;
        rtds_tx_pulse = 1'b0;
        case (state)
            ST_RECV, ST_DROP: s_axis_tready = ready_en;
            ST_SEND: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = mem[rd_ptr];
                m_axis_tlast  = last_word;
                rtds_tx_pulse = ~pulse_done;
            end
            default: ;
        endcase
    end

    // Frame buffer write port; contents need no reset since len gates what is replayed.
    always_ff @(posedge user_clk) begin
        if ((state == ST_RECV) && rx_acc) mem[wr_ptr] <= s_axis_tdata;
    end

    // Pointers, delay counter, statistics and the post-reset ready enable.
    always_ff @(posedge user_clk or posedge sys_reset) begin
        if (sys_reset) begin
            ready_en     <= 1'b0;
            in_frame     <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            len          <= '0;
            dcnt         <= '0;
            pulse_done   <= 1'b0;
            frame_count  <= '0;
            drop_count   <= '0;
            overflow_err <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            in_frame <= in_frame_nxt;

            if (drop_hit) drop_count <= drop_count + CNT_WIDTH'(1);

            case (state)
                ST_RECV: begin
                    if (rx_acc) begin
                        if (s_axis_tlast) begin
                            len    <= LW'(wr_ptr) + LW'(1);
                            dcnt   <= cfg_delay;
                            wr_ptr <= '0;
                        end else if (wr_ptr == LAST_IDX) begin
                            overflow_err <= 1'b1;
                            wr_ptr       <= '0;
                        end else begin
                            wr_ptr <= wr_ptr + AW'(1);
                        end
                    end
                end
                ST_WAIT: dcnt <= dcnt - DELAY_WIDTH'(1);
                ST_SEND: begin
                    pulse_done <= 1'b1;
                    if (tx_end) begin
                        rd_ptr      <= '0;
                        pulse_done  <= 1'b0;
                        frame_count <= frame_count + CNT_WIDTH'(1);
                    end else if (tx_hs) begin
                        rd_ptr <= rd_ptr + AW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rtds_frame_relay.sv
// Directed bench for rtds_frame_relay: relay, delay, TX stall, overflow, busy drop, mid-frame reset.
// Latency: measured between RX tlast handshake and rtds_tx_pulse on negedge samples.
// Backpressure: m_axis_tready driven per test; RX never stalls.
module tb_rtds_frame_relay;

    logic        user_clk = 1'b0;
    logic        sys_reset = 1'b1;
    logic [15:0] cfg_delay = '0;
    logic [31:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tready = 1'b1;
    logic        rtds_tx_pulse;
    logic [15:0] frame_count;
    logic [15:0] drop_count;
    logic        overflow_err;

    rtds_frame_relay #(
        .DATA_WIDTH(32), .MAX_WORDS(64), .DELAY_WIDTH(16), .CNT_WIDTH(16)
    ) dut (
        .user_clk(user_clk), .sys_reset(sys_reset), .cfg_delay(cfg_delay),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .rtds_tx_pulse(rtds_tx_pulse), .frame_count(frame_count),
        .drop_count(drop_count), .overflow_err(overflow_err)
    );

    always #5 user_clk = ~user_clk;

    int checks = 0;
    int failures = 0;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Negedge monitor: TX scoreboard capture, hold-stability and timing bookkeeping.
    int          ncyc = 0;
    int          rx_last_cyc = 0;
    int          pulse_cyc = 0;
    int          pulse_cnt = 0;
    int          hold_err = 0;
    int          stall_cnt = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_dat = '0;
    logic        prev_last = 1'b0;
    logic [31:0] tx_q[$];
    bit          txl_q[$];

    always @(negedge user_clk) begin
        ncyc++;
        if (s_axis_tvalid && s_axis_tready && s_axis_tlast) rx_last_cyc = ncyc;
        if (rtds_tx_pulse) begin
            pulse_cnt++;
            pulse_cyc = ncyc;
        end
        if (prev_stall && (!m_axis_tvalid || m_axis_tdata !== prev_dat || m_axis_tlast !== prev_last))
            hold_err++;
        if (m_axis_tvalid && m_axis_tready) begin
            tx_q.push_back(m_axis_tdata);
            txl_q.push_back(m_axis_tlast);
        end
        if (m_axis_tvalid && !m_axis_tready) stall_cnt++;
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_dat   = m_axis_tdata;
        prev_last  = m_axis_tlast;
    end

    task automatic step();
        @(posedge user_clk);
        #1;
    endtask

    task automatic clear();
        tx_q.delete();
        txl_q.delete();
        pulse_cnt = 0;
        stall_cnt = 0;
        hold_err  = 0;
    endtask

    // One beat per cycle; tlast on the final beat only when with_last is set.
    task automatic send_frame(input logic [31:0] base, input int n, input bit with_last);
        for (int i = 0; i < n; i++) begin
            s_axis_tdata  = base + 32'(i);
            s_axis_tvalid = 1'b1;
            s_axis_tlast  = with_last && (i == n - 1);
            step();
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic wait_tx(input int n);
        for (int i = 0; i < 400 && tx_q.size() < n; i++) step();
        step();
    endtask

    task automatic check_tx(input string tag, input logic [31:0] base, input int n);
        chk_eq({tag, "_len"}, 64'(tx_q.size()), 64'(n));
        for (int i = 0; i < n && i < tx_q.size(); i++) begin
            chk_eq({tag, "_dat"}, 64'(tx_q[i]), 64'(base + 32'(i)));
            chk_eq({tag, "_last"}, 64'(txl_q[i]), 64'(i == n - 1));
        end
    endtask

    logic [3:0] pat = 4'b1001;

    initial begin
        // Reset state.
        repeat (2) @(posedge user_clk);
        #1;
        chk_eq("rst_s_rdy", 64'(s_axis_tready), 64'd0);
        chk_eq("rst_m_vld", 64'(m_axis_tvalid), 64'd0);
        chk_eq("rst_pulse", 64'(rtds_tx_pulse), 64'd0);
        chk_eq("rst_fc", 64'(frame_count), 64'd0);
        chk_eq("rst_dc", 64'(drop_count), 64'd0);
        chk_eq("rst_ovf", 64'(overflow_err), 64'd0);
        sys_reset = 1'b0;
        step();
        chk_eq("rdy_after_rst", 64'(s_axis_tready), 64'd1);

        // 4-word frame, no delay.
        clear();
        cfg_delay = 16'd0;
        send_frame(32'hA000_0000, 4, 1'b1);
        wait_tx(4);
        check_tx("t1", 32'hA000_0000, 4);
        chk_eq("t1_lat", 64'(pulse_cyc - rx_last_cyc), 64'd1);
        chk_eq("t1_pulses", 64'(pulse_cnt), 64'd1);
        chk_eq("t1_fc", 64'(frame_count), 64'd1);

        // Same frame with a 10-cycle inter-packet delay.
        clear();
        cfg_delay = 16'd10;
        send_frame(32'hB000_0000, 4, 1'b1);
        wait_tx(4);
        check_tx("t2", 32'hB000_0000, 4);
        chk_eq("t2_lat", 64'(pulse_cyc - rx_last_cyc), 64'd11);
        chk_eq("t2_fc", 64'(frame_count), 64'd2);

        // TX ready toggling 1,0,0,1: SEND starts 3 cycles in, stalls twice on word 2.
        clear();
        cfg_delay = 16'd3;
        send_frame(32'hC000_0000, 4, 1'b1);
        for (int i = 0; i < 16; i++) begin
            m_axis_tready = pat[i % 4];
            step();
        end
        m_axis_tready = 1'b1;
        check_tx("t3", 32'hC000_0000, 4);
        chk_eq("t3_hold", 64'(hold_err), 64'd0);
        chk_eq("t3_stalls", 64'(stall_cnt), 64'd2);
        chk_eq("t3_pulses", 64'(pulse_cnt), 64'd1);
        chk_eq("t3_fc", 64'(frame_count), 64'd3);

        // 65-word frame overflows and is dropped; following 8-word frame is relayed.
        clear();
        cfg_delay = 16'd0;
        send_frame(32'hD000_0000, 65, 1'b1);
        step();
        chk_eq("t4_ovf", 64'(overflow_err), 64'd1);
        chk_eq("t4_dc", 64'(drop_count), 64'd1);
        chk_eq("t4_no_tx", 64'(tx_q.size()), 64'd0);
        send_frame(32'hE000_0000, 8, 1'b1);
        wait_tx(8);
        check_tx("t4", 32'hE000_0000, 8);
        chk_eq("t4_fc", 64'(frame_count), 64'd4);

        // New 6-word frame starts 2 cycles before a stalled SEND finishes.
        clear();
        m_axis_tready = 1'b0;
        send_frame(32'hF000_0000, 4, 1'b1);
        repeat (3) step();
        chk_eq("t5_stalled", 64'(m_axis_tvalid), 64'd1);
        fork
            m_axis_tready = 1'b1;
            begin
                step();
                send_frame(32'h1000_0000, 6, 1'b1);
            end
        join
        step();
        check_tx("t5", 32'hF000_0000, 4);
        chk_eq("t5_dc", 64'(drop_count), 64'd2);
        chk_eq("t5_fc", 64'(frame_count), 64'd5);
        clear();
        send_frame(32'h2000_0000, 5, 1'b1);
        wait_tx(5);
        check_tx("t5b", 32'h2000_0000, 5);
        chk_eq("t5b_fc", 64'(frame_count), 64'd6);

        // Reset mid-RECV after 3 beats.
        clear();
        send_frame(32'h3000_0000, 3, 1'b0);
        sys_reset = 1'b1;
        #1;
        chk_eq("t6_s_rdy", 64'(s_axis_tready), 64'd0);
        chk_eq("t6_m_vld", 64'(m_axis_tvalid), 64'd0);
        chk_eq("t6_fc", 64'(frame_count), 64'd0);
        chk_eq("t6_dc", 64'(drop_count), 64'd0);
        chk_eq("t6_ovf", 64'(overflow_err), 64'd0);
        step();
        sys_reset = 1'b0;
        step();
        chk_eq("t6_rdy", 64'(s_axis_tready), 64'd1);
        send_frame(32'h4000_0000, 5, 1'b1);
        wait_tx(5);
        check_tx("t6", 32'h4000_0000, 5);
        chk_eq("t6_fc_after", 64'(frame_count), 64'd1);
        chk_eq("t6_dc_after", 64'(drop_count), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
